// File: rtl/pe_out_fork.sv
// Output fork stage behind a PE: buffers the result stream in a small FIFO and
// eagerly broadcasts each head token to the destinations selected by a daisy-chained mask.
module pe_out_fork #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_DEST   = 4,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ctrl_clear,
    output logic                  idle,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [NUM_DEST-1:0]   out_valid,
    input  logic [NUM_DEST-1:0]   out_ready,
    input  logic                  cfg_en,
    input  logic                  cfg_in,
    output logic                  cfg_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] ONE_P   = PW'(1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         count_q, count_d;
    logic [NUM_DEST-1:0]   mask_q, mask_d;
    logic [NUM_DEST-1:0]   sent_q, sent_d;
    logic                  cfg_out_q, cfg_out_d;

    logic                  not_empty;
    logic                  push;
    logic                  pop;
    logic [NUM_DEST-1:0]   fire;
    logic [NUM_DEST-1:0]   mask_shift;

    generate
        if (NUM_DEST == 1) begin : g_one_dest
            assign mask_shift = cfg_in;
        end else begin : g_many_dest
            assign mask_shift = {cfg_in, mask_q[NUM_DEST-1:1]};
        end
    endgenerate

    assign not_empty = (count_q != '0);
    assign idle      = ~not_empty;
    assign in_ready  = (count_q < DEPTH_P) & ~cfg_en & ~ctrl_clear;
    assign push      = in_valid & in_ready;
    assign out_data  = mem_q[rd_ptr_q[AW-1:0]];
    assign out_valid = {NUM_DEST{not_empty & ~cfg_en}} & mask_q & ~sent_q;
    assign fire      = out_valid & out_ready;
    // A destination is done once it is unselected, already served, or taking the token now.
    assign pop       = not_empty & ~cfg_en & (&(~mask_q | sent_q | fire));
    assign cfg_out   = cfg_out_q;

    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        sent_d    = sent_q;
        mask_d    = mask_q;
        cfg_out_d = cfg_out_q;

        if (cfg_en) begin
            mask_d    = mask_shift;
            cfg_out_d = mask_q[0];
        end

        if (cfg_en || ctrl_clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            sent_d   = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + ONE_P;
            if (pop)  rd_ptr_d = rd_ptr_q + ONE_P;
            if (push && !pop)      count_d = count_q + ONE_P;
            else if (!push && pop) count_d = count_q - ONE_P;
            sent_d = pop ? '0 : (sent_q | fire);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            mask_q    <= '0;
            sent_q    <= '0;
            cfg_out_q <= 1'b0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            mask_q    <= mask_d;
            sent_q    <= sent_d;
            cfg_out_q <= cfg_out_d;
        end
    end

    // Storage holds only data qualified by count, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= in_data;
    end

endmodule

// File: tb/tb_pe_out_fork.sv
// Directed bench for pe_out_fork: configuration chain, partial forks, backpressure,
// streaming, clear, drop-sink mask and asynchronous reset.
module tb_pe_out_fork;

    logic        clk;
    logic        rst_n;
    logic        ctrl_clear;
    logic        idle;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic        cfg_en;
    logic        cfg_in;
    logic        cfg_out;

    int compared   = 0;
    int mismatched = 0;
    int dest0_11   = 0;

    pe_out_fork #(.DATA_WIDTH(32), .NUM_DEST(4), .DEPTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ctrl_clear(ctrl_clear),
        .idle      (idle),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cfg_en    (cfg_en),
        .cfg_in    (cfg_in),
        .cfg_out   (cfg_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts deliveries of token 0x11 to destination 0.
    always @(negedge clk) begin
        if (rst_n && out_valid[0] && out_ready[0] && out_data == 32'h11) dest0_11++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_one(input logic [31:0] d);
        in_data  = d;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic shift_cfg(input logic [3:0] bits_first_lsb, input logic [3:0] exp_out, input string tag);
        cfg_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cfg_in = bits_first_lsb[i];
            #1;
            check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd0);
            check({tag, "_out_valid"}, {28'b0, out_valid}, 32'd0);
            tick();
            check({tag, "_cfg_out"}, {31'b0, cfg_out}, {31'b0, exp_out[i]});
        end
        cfg_en = 1'b0;
        cfg_in = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; ctrl_clear = 1'b0; in_data = '0; in_valid = 1'b0;
        out_ready = '0; cfg_en = 1'b0; cfg_in = 1'b0;
        #12;
        check("rst_out_valid", {28'b0, out_valid}, 32'd0);
        check("rst_idle", {31'b0, idle}, 32'd1);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_cfg_out", {31'b0, cfg_out}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Shift 1,0,1,1 -> mask 4'b1101; old mask bits leave as zeros.
        shift_cfg(4'b1101, 4'b0000, "cfg1");
        push_one(32'hA5);
        check("a5_out_valid", {28'b0, out_valid}, 32'h0000000D);
        check("a5_out_data", out_data, 32'hA5);
        check("a5_idle", {31'b0, idle}, 32'd0);
        out_ready = 4'b1111;
        tick();
        out_ready = 4'b0000;
        check("a5_drained_idle", {31'b0, idle}, 32'd1);

        // Partial acceptance of 0x11 with 0x12 queued behind it.
        push_one(32'h11);
        push_one(32'h12);
        check("p0_out_valid", {28'b0, out_valid}, 32'h0000000D);
        check("p0_out_data", out_data, 32'h11);
        check("p0_in_ready_full", {31'b0, in_ready}, 32'd0);
        out_ready = 4'b0001;
        tick();
        check("p1_out_valid", {28'b0, out_valid}, 32'h0000000C);
        out_ready = 4'b0101;
        tick();
        check("p2_out_valid", {28'b0, out_valid}, 32'h00000008);
        check("p2_out_data", out_data, 32'h11);
        out_ready = 4'b1001;
        tick();
        out_ready = 4'b0000;
        check("p3_out_valid", {28'b0, out_valid}, 32'h0000000D);
        check("p3_out_data", out_data, 32'h12);
        check("p3_dest0_once", dest0_11, 32'd1);
        out_ready = 4'b1111;
        tick();
        out_ready = 4'b0000;
        check("p4_idle", {31'b0, idle}, 32'd1);

        // Backpressure: three pushes, only two fit.
        in_valid = 1'b1;
        in_data = 32'h21; #1;
        check("bp_rdy0", {31'b0, in_ready}, 32'd1);
        tick();
        in_data = 32'h22;
        check("bp_rdy1", {31'b0, in_ready}, 32'd1);
        tick();
        in_data = 32'h23; #1;
        check("bp_rdy2", {31'b0, in_ready}, 32'd0);
        tick();
        in_valid = 1'b0;
        out_ready = 4'b1111; #1;
        check("bp_head0", out_data, 32'h21);
        check("bp_valid0", {28'b0, out_valid}, 32'h0000000D);
        tick();
        check("bp_head1", out_data, 32'h22);
        check("bp_valid1", {28'b0, out_valid}, 32'h0000000D);
        tick();
        check("bp_idle", {31'b0, idle}, 32'd1);
        out_ready = 4'b0000;

        // Reload mask to 4'b1111; the old mask 1101 exits the chain LSB first.
        shift_cfg(4'b1111, 4'b1101, "cfg2");

        // Stream 0..7 with every destination ready.
        out_ready = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            in_data = 32'(i);
            in_valid = 1'b1;
            #1;
            check($sformatf("st_in_ready_%0d", i), {31'b0, in_ready}, 32'd1);
            if (i > 0) begin
                check($sformatf("st_data_%0d", i - 1), out_data, 32'(i - 1));
                check($sformatf("st_valid_%0d", i - 1), {28'b0, out_valid}, 32'h0000000F);
            end
            tick();
        end
        in_valid = 1'b0;
        check("st_data_7", out_data, 32'd7);
        check("st_valid_7", {28'b0, out_valid}, 32'h0000000F);
        tick();
        check("st_idle", {31'b0, idle}, 32'd1);
        out_ready = 4'b0000;

        // ctrl_clear with two queued tokens and destination 0 already served.
        push_one(32'h31);
        push_one(32'h32);
        out_ready = 4'b0001;
        tick();
        out_ready = 4'b0000;
        check("clr_pre_valid", {28'b0, out_valid}, 32'h0000000E);
        ctrl_clear = 1'b1; #1;
        check("clr_in_ready", {31'b0, in_ready}, 32'd0);
        tick();
        ctrl_clear = 1'b0;
        check("clr_idle", {31'b0, idle}, 32'd1);
        check("clr_out_valid", {28'b0, out_valid}, 32'd0);
        push_one(32'h22);
        check("clr_new_valid", {28'b0, out_valid}, 32'h0000000F);
        check("clr_new_data", out_data, 32'h22);
        out_ready = 4'b1111;
        tick();
        out_ready = 4'b0000;

        // mask = 0: token is dropped without ever being offered.
        shift_cfg(4'b0000, 4'b1111, "cfg3");
        push_one(32'h33);
        check("drop_valid", {28'b0, out_valid}, 32'd0);
        tick();
        check("drop_idle", {31'b0, idle}, 32'd1);

        // Asynchronous reset in the middle of a fork.
        shift_cfg(4'b1111, 4'b0000, "cfg4");
        push_one(32'h44);
        out_ready = 4'b0001;
        tick();
        out_ready = 4'b0000;
        check("ar_pre_valid", {28'b0, out_valid}, 32'h0000000E);
        rst_n = 1'b0; #1;
        check("ar_out_valid", {28'b0, out_valid}, 32'd0);
        check("ar_idle", {31'b0, idle}, 32'd1);
        check("ar_in_ready", {31'b0, in_ready}, 32'd1);
        #1;
        rst_n = 1'b1;
        push_one(32'h55);
        check("ar_mask_cleared", {28'b0, out_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
